// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension path: format selects, data width
// and the entry carried through the output/skid registers.
package imm_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] SRC_IMM_I    = 3'd0;
  localparam logic [2:0] SRC_IMM_S    = 3'd1;
  localparam logic [2:0] SRC_IMM_B    = 3'd2;
  localparam logic [2:0] SRC_IMM_U    = 3'd3;
  localparam logic [2:0] SRC_IMM_J    = 3'd4;
  localparam logic [2:0] SRC_IMM_NONE = 3'd7;

  // One finished pipeline entry; the immediate is already extended when stored.
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] inst;
  } imm_entry_t;

  // Carry out is intentionally dropped so PC-relative targets wrap silently.
  function automatic logic [XLEN-1:0] imm_target(input logic [XLEN-1:0] pc,
                                                 input logic [XLEN-1:0] imm);
    return pc + imm;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate decoder: selects and sign-extends the immediate field
// of a 32-bit instruction word according to the format chosen by the opcode decoder.
module imm_gen
  import imm_pkg::*;
(
  input  logic [XLEN-1:0] i_inst,
  input  logic [2:0]      i_src_imm,
  output logic [XLEN-1:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_src_imm)
      SRC_IMM_I: o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      SRC_IMM_S: o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      SRC_IMM_B: o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                          i_inst[30:25], i_inst[11:8], 1'b0};
      SRC_IMM_U: o_imm = {i_inst[31:12], 12'b0};
      SRC_IMM_J: o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                          i_inst[20], i_inst[30:21], 1'b0};
      // R-type and system formats carry no immediate.
      default:   o_imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage with valid/ready on both sides.
// Define IMM_SKID_EN to add a one-entry skid register and a registered o_ready.
module imm_ext_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [2:0]      i_src_imm,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_inst
);

  import imm_pkg::*;

  logic [XLEN-1:0] gen_imm;
  imm_entry_t      in_entry;
  imm_entry_t      out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            accept;
  logic            transfer;

  imm_gen u_imm_gen (
    .i_inst    (i_inst),
    .i_src_imm (i_src_imm),
    .o_imm     (gen_imm)
  );

  always_comb begin
    in_entry        = '0;
    in_entry.imm    = gen_imm;
    in_entry.target = imm_target(i_pc, gen_imm);
    in_entry.inst   = i_inst;
  end

  // A flushed cycle never counts as an accept, so no data register moves on it.
  assign accept   = i_valid && o_ready && !i_flush;
  assign transfer = out_valid_q && i_ready;

`ifdef IMM_SKID_EN

  imm_entry_t skid_q, skid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       ready_q, ready_d;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // o_ready is low here, so the only possible move is draining the skid entry.
      if (transfer) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || transfer) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end else if (transfer) begin
      out_valid_d = 1'b0;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign o_ready = ready_q;

`else

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (i_flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = in_entry;
      out_valid_d = 1'b1;
    end else if (transfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Without a skid slot the stage can only take a new entry as the current one leaves.
  assign o_ready = !out_valid_q || i_ready;

`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_valid  = out_valid_q;
  assign o_imm    = out_q.imm;
  assign o_target = out_q.target;
  assign o_inst   = out_q.inst;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed plus randomised bench for imm_ext_stage with a scoreboard queue.
// Expectations adapt to whether IMM_SKID_EN is defined.
module tb_imm_ext_stage;

  logic        i_clk;
  logic        i_rstn;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic [2:0]  i_src_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_imm;
  logic [31:0] o_target;
  logic [31:0] o_inst;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] target;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  src;
  } stim_t;

  exp_t  sb[$];
  stim_t pend[$];
  int    total = 0;
  int    bad   = 0;
  logic  last_acc;

`ifdef IMM_SKID_EN
  localparam int EXP_BP_ACC = 2;
`else
  localparam int EXP_BP_ACC = 1;
`endif

  imm_ext_stage #(.XLEN(32)) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_flush   (i_flush),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_inst    (i_inst),
    .i_pc      (i_pc),
    .i_src_imm (i_src_imm),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_imm     (o_imm),
    .o_target  (o_target),
    .o_inst    (o_inst)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] ref_imm(logic [31:0] w, logic [2:0] s);
    case (s)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {w[31:12], 12'b0};
      3'd4:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(logic [31:0] inst, logic [31:0] pc, logic [2:0] src);
    i_valid   = 1'b1;
    i_inst    = inst;
    i_pc      = pc;
    i_src_imm = src;
  endtask

  // One clock: score the transfer and acceptance seen before the edge, then step.
  task automatic cycle();
    exp_t e;
    @(negedge i_clk);
    last_acc = i_valid && o_ready && !i_flush;
    if (o_valid && i_ready && !i_flush) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_imm", o_imm, e.imm);
        chk("sb_target", o_target, e.target);
        chk("sb_inst", o_inst, e.inst);
      end
    end
    if (i_flush) begin
      sb.delete();
    end else if (last_acc) begin
      e.imm    = ref_imm(i_inst, i_src_imm);
      e.target = i_pc + e.imm;
      e.inst   = i_inst;
      sb.push_back(e);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic dstep(string tag, logic [31:0] inst, logic [31:0] pc, logic [2:0] src,
                       logic [31:0] exp_imm, logic [31:0] exp_tgt);
    drive(inst, pc, src);
    cycle();
    chk({tag, "_acc"}, 32'(last_acc), 32'd1);
    chk({tag, "_vld"}, 32'(o_valid), 32'd1);
    chk({tag, "_imm"}, o_imm, exp_imm);
    chk({tag, "_tgt"}, o_target, exp_tgt);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_vld"}, 32'(o_valid), 32'd0);
    chk({tag, "_rdy"}, 32'(o_ready), 32'd1);
    chk({tag, "_imm"}, o_imm, 32'd0);
    chk({tag, "_tgt"}, o_target, 32'd0);
    chk({tag, "_inst"}, o_inst, 32'd0);
  endtask

  initial begin
    int    acc;
    stim_t s;
    i_rstn = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_inst = '0; i_pc = '0; i_src_imm = '0; last_acc = 1'b0;

    #2;
    chk_reset_vals("rst");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    // Back-to-back directed formats with downstream always ready.
    i_ready = 1'b1;
    dstep("itype", 32'hFFF00093, 32'h0000_0100, 3'd0, 32'hFFFF_FFFF, 32'h0000_00FF);
    chk("itype_inst", o_inst, 32'hFFF00093);
    dstep("stype", 32'h00112223, 32'h0000_0200, 3'd1, 32'h0000_0004, 32'h0000_0204);
    dstep("utype", 32'h12345037, 32'h0000_0000, 3'd3, 32'h1234_5000, 32'h1234_5000);
    dstep("btype", 32'hFE000EE3, 32'h0000_1000, 3'd2, 32'hFFFF_FFFC, 32'h0000_0FFC);
    dstep("jwrap", 32'h0080006F, 32'hFFFF_FFFC, 3'd4, 32'h0000_0008, 32'h0000_0004);
    dstep("src5", 32'hFFFFFFFF, 32'h0000_ABC0, 3'd5, 32'h0, 32'h0000_ABC0);
    dstep("src6", 32'hFFFFFFFF, 32'h0000_1234, 3'd6, 32'h0, 32'h0000_1234);
    dstep("src7", 32'hFFFFFFFF, 32'hDEAD_0000, 3'd7, 32'h0, 32'hDEAD_0000);
    i_valid = 1'b0;
    cycle();
    cycle();
    chk("idle_vld", 32'(o_valid), 32'd0);

    // Back-pressure: three entries offered while downstream stalls for three cycles.
    pend.delete();
    s.inst = 32'h00500093; s.pc = 32'h40; s.src = 3'd0; pend.push_back(s);
    s.inst = 32'h00A12423; s.pc = 32'h44; s.src = 3'd1; pend.push_back(s);
    s.inst = 32'hABCDE0B7; s.pc = 32'h48; s.src = 3'd3; pend.push_back(s);
    acc = 0;
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(pend[0].inst, pend[0].pc, pend[0].src);
      cycle();
      if (last_acc) begin
        void'(pend.pop_front());
        acc++;
      end
      chk("bp_hold_imm", o_imm, 32'h0000_0005);
    end
    chk("bp_accepts", 32'(acc), 32'(EXP_BP_ACC));
    chk("bp_ready", 32'(o_ready), 32'd0);
    i_ready = 1'b1;
    for (int k = 0; k < 10 && pend.size() != 0; k++) begin
      drive(pend[0].inst, pend[0].pc, pend[0].src);
      cycle();
      if (last_acc) void'(pend.pop_front());
    end
    chk("bp_all_acc", 32'(pend.size()), 32'd0);
    i_valid = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) cycle();
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Random traffic; an offered entry is held until it is accepted.
    s.inst = $urandom; s.pc = $urandom; s.src = 3'($urandom_range(0, 7));
    for (int k = 0; k < 60; k++) begin
      if (last_acc) begin
        s.inst = $urandom; s.pc = $urandom; s.src = 3'($urandom_range(0, 7));
      end
      drive(s.inst, s.pc, s.src);
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) cycle();
    chk("rnd_drained", 32'(sb.size()), 32'd0);

    // Flush with the stage stalled and full; the entry presented alongside is dropped.
    i_ready = 1'b0;
    drive(32'h7FF00113, 32'h80, 3'd0);
    cycle();
    drive(32'h00100193, 32'h84, 3'd0);
    cycle();
    chk("fl_pre_rdy", 32'(o_ready), 32'd0);
    i_flush = 1'b1;
    drive(32'h00200213, 32'h88, 3'd0);
    cycle();
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("fl_vld", 32'(o_valid), 32'd0);
    chk("fl_rdy", 32'(o_ready), 32'd1);
    chk("fl_data_kept", o_inst, 32'h7FF00113);
    i_ready = 1'b1;
    cycle();
    chk("fl_still_idle", 32'(o_valid), 32'd0);

    // Asynchronous reset asserted between clock edges.
    i_ready = 1'b0;
    drive(32'hFFF00093, 32'h100, 3'd0);
    cycle();
    i_valid = 1'b0;
    chk("ar_pre_vld", 32'(o_valid), 32'd1);
    #2;
    i_rstn = 1'b0;
    #1;
    chk_reset_vals("ar");
    sb.delete();
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    chk("ar_post_vld", 32'(o_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
